// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: state encoding,
// EX/MEM control bit positions and default bundle widths.
package pipe_pkg;

    localparam int unsigned CTRL_W_EXMEM = 6;
    localparam int unsigned DATA_W_EXMEM = 69;

    // EX/MEM control bundle bit positions
    localparam int unsigned EXMEM_REGWRITE = 5;
    localparam int unsigned EXMEM_MEMTOREG = 4;
    localparam int unsigned EXMEM_MEMREAD  = 3;
    localparam int unsigned EXMEM_MEMWRITE = 2;
    localparam int unsigned EXMEM_PCSRC_HI = 1;
    localparam int unsigned EXMEM_PCSRC_LO = 0;

    // Code doubles as the occupancy count
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } skid_state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid bit, control bundle and data bundle.
// Reset clears everything; clear_ctrl drops valid and control but keeps data.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        CTRL_W     = CTRL_W_EXMEM,
    parameter int unsigned        DATA_W     = DATA_W_EXMEM,
    parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear_ctrl,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    output logic              valid_q,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= RESET_DATA;
        end else if (clear_ctrl) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid
// buffer; every output, including in_ready, comes straight from a flop.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned        CTRL_W     = CTRL_W_EXMEM,
    parameter int unsigned        DATA_W     = DATA_W_EXMEM,
    parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    skid_state_e       state_q, state_d;
    logic              in_ready_q;
    logic              push, pop;
    logic              main_load, main_clr, main_from_skid;
    logic              skid_load, skid_clr;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl, main_ctrl_d;
    logic [DATA_W-1:0] skid_data, main_data_d;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid & out_ready;

    // Next state and entry control; flush overrides any handshake
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        main_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        skid_load = 1'b1;
                        state_d   = ST_TWO;
                    end else if (push && pop) begin
                        main_load = 1'b1;
                    end else if (pop) begin
                        main_clr = 1'b1;
                        state_d  = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_data_d = main_from_skid ? skid_data : in_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    pipe_entry_reg #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .RESET_DATA (RESET_DATA)
    ) u_main (
        .clock      (clock),
        .reset      (reset),
        .load       (main_load),
        .clear_ctrl (main_clr),
        .ctrl_d     (main_ctrl_d),
        .data_d     (main_data_d),
        .valid_q    (out_valid),
        .ctrl_q     (out_ctrl),
        .data_q     (out_data)
    );

    pipe_entry_reg #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .RESET_DATA (RESET_DATA)
    ) u_skid (
        .clock      (clock),
        .reset      (reset),
        .load       (skid_load),
        .clear_ctrl (skid_clr),
        .ctrl_d     (in_ctrl),
        .data_d     (in_data),
        .valid_q    (skid_valid),
        .ctrl_q     (skid_ctrl),
        .data_q     (skid_data)
    );

    assign in_ready  = in_ready_q;
    assign occupancy = 2'(state_q);

    // Skid valid mirrors state TWO; kept for waveform visibility only
    logic unused_skid_valid;
    assign unused_skid_valid = skid_valid;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed testbench for pipe_skid_stage: reset, streaming, backpressure,
// flush, random-ready ordering and reset/flush priority.
module tb_pipe_skid_stage;

    localparam int unsigned CW = 6;
    localparam int unsigned DW = 69;

    logic          clock;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_skid_stage dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; outputs are sampled and inputs driven 1ns after the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 6'h3F; in_data = 69'h55;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_cmp++; if (out_ctrl !== 6'h00) begin n_fail++; $display("FAIL reset_out_ctrl got %h exp 00", out_ctrl); end
        n_cmp++; if (out_data !== 69'h0) begin n_fail++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
        reset = 1'b0; in_valid = 1'b0;
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_push_dropped got %b exp 0", out_valid); end
    endtask

    task automatic test_stream();
        logic [DW-1:0] exp_d;
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_ctrl = CW'(i); in_data = DW'(i);
            step();
            exp_d = DW'(i);
            n_cmp++; if (out_data !== exp_d || out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_data_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_d); end
            n_cmp++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_occ_%0d got occ=%0d rdy=%b exp occ=1 rdy=1", i, occupancy, in_ready); end
        end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0 || out_ctrl !== 6'h00 || occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_drain got v=%b c=%h occ=%0d exp v=0 c=00 occ=0", out_valid, out_ctrl, occupancy); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 6'h21; in_data = 69'h1;
        step();
        in_ctrl = 6'h12; in_data = 69'h2;
        step();
        n_cmp++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got occ=%0d rdy=%b exp occ=2 rdy=0", occupancy, in_ready); end
        in_ctrl = 6'h0C; in_data = 69'h3;
        step();
        n_cmp++; if (occupancy !== 2'd2 || out_data !== 69'h1 || out_ctrl !== 6'h21) begin n_fail++; $display("FAIL bp_hold got occ=%0d d=%h c=%h exp occ=2 d=1 c=21", occupancy, out_data, out_ctrl); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_data !== 69'h2 || out_ctrl !== 6'h12 || occupancy !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_b got d=%h c=%h occ=%0d rdy=%b exp d=2 c=12 occ=1 rdy=1", out_data, out_ctrl, occupancy, in_ready); end
        step();
        n_cmp++; if (out_data !== 69'h3 || out_ctrl !== 6'h0C || out_valid !== 1'b1 || occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_c got d=%h c=%h v=%b occ=%0d exp d=3 c=0c v=1 occ=1", out_data, out_ctrl, out_valid, occupancy); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL bp_no_dup got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 6'h2A; in_data = 69'hA;
        step();
        in_ctrl = 6'h15; in_data = 69'hB;
        step();
        flush = 1'b1; in_ctrl = 6'h3F; in_data = 69'hC; out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0 || out_ctrl !== 6'h00 || occupancy !== 2'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_bubble got v=%b c=%h occ=%0d rdy=%b exp v=0 c=00 occ=0 rdy=1", out_valid, out_ctrl, occupancy, in_ready); end
        n_cmp++; if (out_data !== 69'hA) begin n_fail++; $display("FAIL flush_data_hold got %h exp a", out_data); end
        flush = 1'b0; in_ctrl = 6'h05; in_data = 69'h4;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_ctrl !== 6'h05 || out_data !== 69'h4 || occupancy !== 2'd1) begin n_fail++; $display("FAIL flush_push_d got v=%b c=%h d=%h occ=%0d exp v=1 c=05 d=4 occ=1", out_valid, out_ctrl, out_data, occupancy); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0 || out_ctrl !== 6'h00 || occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_no_residue got v=%b c=%h occ=%0d exp v=0 c=00 occ=0", out_valid, out_ctrl, occupancy); end
    endtask

    // Reference queue model with randomised in_valid/out_ready
    task automatic test_back_to_back();
        logic [DW-1:0] qd[$];
        logic [CW-1:0] qc[$];
        int            m_occ;
        int            tag;
        logic          m_rdy, iv, ordy, do_push, do_pop;
        m_occ = 0; tag = 16;
        for (int cyc = 0; cyc < 30; cyc++) begin
            m_rdy = (m_occ < 2);
            n_cmp++; if (in_ready !== m_rdy || occupancy !== 2'(m_occ) || out_valid !== (m_occ > 0)) begin n_fail++; $display("FAIL b2b_state_%0d got rdy=%b occ=%0d v=%b exp rdy=%b occ=%0d", cyc, in_ready, occupancy, out_valid, m_rdy, m_occ); end
            iv   = (cyc >= 24) ? 1'b0 : ($urandom_range(0, 3) != 0);
            ordy = (cyc >= 24) ? 1'b1 : 1'($urandom_range(0, 1));
            in_valid = iv; out_ready = ordy;
            in_data = DW'(tag); in_ctrl = CW'(tag);
            do_push = iv && m_rdy;
            do_pop  = (m_occ > 0) && ordy;
            if (do_pop) begin
                n_cmp++; if (out_data !== qd[0] || out_ctrl !== qc[0]) begin n_fail++; $display("FAIL b2b_order_%0d got d=%h c=%h exp d=%h c=%h", cyc, out_data, out_ctrl, qd[0], qc[0]); end
                void'(qd.pop_front());
                void'(qc.pop_front());
            end
            if (do_push) begin
                qd.push_back(DW'(tag));
                qc.push_back(CW'(tag));
                tag++;
            end
            m_occ = m_occ + int'(do_push) - int'(do_pop);
            step();
        end
        in_valid = 1'b0;
        n_cmp++; if (qd.size() != 0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL b2b_drained got left=%0d occ=%0d exp left=0 occ=0", qd.size(), occupancy); end
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 6'h11; in_data = 69'h77;
        step();
        in_ctrl = 6'h22; in_data = 69'h88;
        step();
        n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL rf_fill got occ=%0d exp 2", occupancy); end
        reset = 1'b1; flush = 1'b1;
        step();
        n_cmp++; if (out_data !== 69'h0 || out_valid !== 1'b0 || out_ctrl !== 6'h00 || occupancy !== 2'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rf_reset_wins got d=%h v=%b c=%h occ=%0d rdy=%b exp d=0 v=0 c=00 occ=0 rdy=1", out_data, out_valid, out_ctrl, occupancy, in_ready); end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        step();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
